// File: rtl/vga_pkg.sv
// Shared VGA display geometry, ball/bar constants and play-state encoding.
// Constants only; no logic, no latency.
package vga_pkg;

    localparam int H_DISP      = 640;
    localparam int V_DISP      = 480;
    localparam int BALL_SIZE   = 8;
    localparam int BALL_V      = 2;
    localparam int WALL_X_R    = 45;
    localparam int BAR_X_L     = 450;
    localparam int BAR_X_R     = 500;
    localparam int BAR_Y_SIZE  = 50;
    localparam int START_X     = 320;
    localparam int START_Y     = 240;
    localparam int MISS_FRAMES = 60;
    localparam logic [2:0] BALL_RGB = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_MISS = 2'b10
    } state_t;

    // 11-bit signed so a step past either screen edge stays representable
    typedef logic signed [10:0] coord_t;

    localparam coord_t C_ZERO       = '0;
    localparam coord_t C_V          = coord_t'(BALL_V);
    localparam coord_t C_Y_MAX      = coord_t'(V_DISP - BALL_SIZE);
    localparam coord_t C_WALL_LIM   = coord_t'(WALL_X_R + 1);
    localparam coord_t C_BALL_M1    = coord_t'(BALL_SIZE - 1);
    localparam coord_t C_BAR_X_L    = coord_t'(BAR_X_L);
    localparam coord_t C_BAR_X_R    = coord_t'(BAR_X_R);
    localparam coord_t C_BAR_H_M1   = coord_t'(BAR_Y_SIZE - 1);
    localparam coord_t C_BAR_BOUNCE = coord_t'(BAR_X_L - BALL_SIZE);
    localparam coord_t C_H_DISP     = coord_t'(H_DISP);

endpackage

// File: rtl/frame_tick_gen.sv
// One-clock frame tick on the rising edge of (pixel_y==TICK_ROW && pixel_x==0).
// Tick is combinational from the pixel inputs; no backpressure.
module frame_tick_gen
    import vga_pkg::*;
#(
    parameter int TICK_ROW = V_DISP + 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    output logic       o_tick
);

    logic w_hit;
    logic r_hit_d;

    assign w_hit = (i_pixel_y == 10'(TICK_ROW)) && (i_pixel_x == 10'd0);

    // edge detect so a pixel pair held for several clocks yields one tick
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_d <= 1'b0;
        end else begin
            r_hit_d <= w_hit;
        end
    end

    assign o_tick = w_hit && !r_hit_d;

endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball position/velocity/play-state owner, updated once per frame tick; ball_on is
// combinational from the pixel inputs, ball_x/ball_y/state/miss are registered.
module pong_ball_ctrl
    import vga_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic       i_video_on,
    input  logic [9:0] i_bar_y_t,
    input  logic       i_start,
    output logic       o_ball_on,
    output logic [2:0] o_ball_rgb,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_miss,
    output logic [1:0] o_state
);

    state_t     r_state, w_state_nxt;
    logic [9:0] r_ball_x, r_ball_y, w_x_nxt, w_y_nxt;
    logic       r_dx_neg, r_dy_neg, w_dx_neg_nxt, w_dy_neg_nxt;
    logic [5:0] r_miss_cnt, w_cnt_nxt;
    logic       r_miss, w_miss_nxt;
    logic       w_tick;

    coord_t w_bx, w_by, w_bar_t, w_xn, w_yn;
    logic   w_dx_neg_n, w_dy_neg_n, w_bar_hit, w_miss_hit;

    frame_tick_gen u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pixel_x (i_pixel_x),
        .i_pixel_y (i_pixel_y),
        .o_tick    (w_tick)
    );

    // candidate motion for this frame: y bounce, then wall, then bar, then miss
    always_comb begin
        w_bx    = coord_t'({1'b0, r_ball_x});
        w_by    = coord_t'({1'b0, r_ball_y});
        w_bar_t = coord_t'({1'b0, i_bar_y_t});

        w_dy_neg_n = r_dy_neg;
        w_yn       = w_by + (r_dy_neg ? -C_V : C_V);
        if (w_yn <= C_ZERO) begin
            w_yn       = C_ZERO;
            w_dy_neg_n = 1'b0;
        end else if (w_yn >= C_Y_MAX) begin
            w_yn       = C_Y_MAX;
            w_dy_neg_n = 1'b1;
        end

        w_dx_neg_n = r_dx_neg;
        w_xn       = w_bx + (r_dx_neg ? -C_V : C_V);
        if (w_xn <= C_WALL_LIM) begin
            w_xn       = C_WALL_LIM;
            w_dx_neg_n = 1'b0;
        end

        w_bar_hit = !w_dx_neg_n
                 && (w_xn + C_BALL_M1 >= C_BAR_X_L)
                 && (w_bx <= C_BAR_X_R)
                 && (w_yn + C_BALL_M1 >= w_bar_t)
                 && (w_yn <= w_bar_t + C_BAR_H_M1);
        if (w_bar_hit) begin
            w_xn       = C_BAR_BOUNCE;
            w_dx_neg_n = 1'b1;
        end

        w_miss_hit = !w_bar_hit && (w_xn + C_BALL_M1 >= C_H_DISP);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_ball_x;
        w_y_nxt      = r_ball_y;
        w_dx_neg_nxt = r_dx_neg;
        w_dy_neg_nxt = r_dy_neg;
        w_cnt_nxt    = r_miss_cnt;
        w_miss_nxt   = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) w_state_nxt = ST_PLAY;
                end
                ST_PLAY: begin
                    w_x_nxt      = w_xn[9:0];
                    w_y_nxt      = w_yn[9:0];
                    w_dx_neg_nxt = w_dx_neg_n;
                    w_dy_neg_nxt = w_dy_neg_n;
                    if (w_miss_hit) begin
                        w_state_nxt = ST_MISS;
                        w_miss_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_MISS: begin
                    if (r_miss_cnt == 6'(MISS_FRAMES - 1)) begin
                        w_state_nxt  = ST_IDLE;
                        w_x_nxt      = 10'(START_X);
                        w_y_nxt      = 10'(START_Y);
                        w_dx_neg_nxt = 1'b0;
                        w_dy_neg_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_miss_cnt + 6'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_ball_x   <= 10'(START_X);
            r_ball_y   <= 10'(START_Y);
            r_dx_neg   <= 1'b0;
            r_dy_neg   <= 1'b0;
            r_miss_cnt <= '0;
            r_miss     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ball_x   <= w_x_nxt;
            r_ball_y   <= w_y_nxt;
            r_dx_neg   <= w_dx_neg_nxt;
            r_dy_neg   <= w_dy_neg_nxt;
            r_miss_cnt <= w_cnt_nxt;
            r_miss     <= w_miss_nxt;
        end
    end

    assign o_ball_on = i_video_on && (r_state != ST_MISS)
                    && (i_pixel_x >= r_ball_x)
                    && ({1'b0, i_pixel_x} <= {1'b0, r_ball_x} + 11'(BALL_SIZE - 1))
                    && (i_pixel_y >= r_ball_y)
                    && ({1'b0, i_pixel_y} <= {1'b0, r_ball_y} + 11'(BALL_SIZE - 1));

    assign o_ball_rgb = BALL_RGB;
    assign o_ball_x   = r_ball_x;
    assign o_ball_y   = r_ball_y;
    assign o_miss     = r_miss;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scenario bench for pong_ball_ctrl: expectations are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_pong_ball_ctrl;

    logic       clk = 1'b0;
    logic       rst, video_on, start;
    logic [9:0] px, py, bar_y_t;
    logic       ball_on, miss;
    logic [2:0] ball_rgb;
    logic [9:0] ball_x, ball_y;
    logic [1:0] state;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   miss_seen = 0;

    always #5 clk = ~clk;

    pong_ball_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pixel_x  (px),
        .i_pixel_y  (py),
        .i_video_on (video_on),
        .i_bar_y_t  (bar_y_t),
        .i_start    (start),
        .o_ball_on  (ball_on),
        .o_ball_rgb (ball_rgb),
        .o_ball_x   (ball_x),
        .o_ball_y   (ball_y),
        .o_miss     (miss),
        .o_state    (state)
    );

    always @(negedge clk) if (miss === 1'b1) miss_seen++;

    task automatic push(input string n, input int v);
        sb.push_back('{n, v});
    endtask

    // one frame: tick pixel pair for one clock, then back to the top-left
    task automatic frame();
        @(negedge clk);
        px = 10'd0;
        py = 10'd481;
        @(negedge clk);
        py = 10'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        px  = 10'd0;
        py  = 10'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; video_on = 1'b1; start = 1'b0; bar_y_t = 10'd0;
        px = 10'd0; py = 10'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push("rst_state", 0); push("rst_x", 320); push("rst_y", 240);
        push("rst_miss", 0); push("rst_rgb", 2);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(miss) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, miss, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_rgb) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_rgb, e.val); end

        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin px = 10'd320; py = 10'd240; video_on = 1'b1; push("on_320_240", 1); end
                1: begin px = 10'd327; py = 10'd247; video_on = 1'b1; push("on_327_247", 1); end
                2: begin px = 10'd328; py = 10'd240; video_on = 1'b1; push("on_328_240", 0); end
                3: begin px = 10'd320; py = 10'd248; video_on = 1'b1; push("on_320_248", 0); end
                default: begin px = 10'd320; py = 10'd240; video_on = 1'b0; push("on_video_off", 0); end
            endcase
            #1;
            e = sb.pop_front(); n_vec++;
            if (int'(ball_on) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_on, e.val); end
        end
        video_on = 1'b1; px = 10'd0; py = 10'd0;
    endtask

    task automatic test_bar_bounce();
        do_reset();
        bar_y_t = 10'd340; start = 1'b1; miss_seen = 0;
        frame();
        push("launch_state", 1); push("launch_x", 320);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end

        for (int t = 1; t <= 62; t++) frame();
        push("bar_hit_x_t62", 442);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        frame();
        push("bar_retreat_x_t63", 440);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end

        for (int t = 64; t <= 116; t++) frame();
        push("floor_y_t116", 472);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end
        frame();
        push("floor_up_y_t117", 470);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end

        for (int t = 118; t <= 260; t++) frame();
        push("wall_x_t260", 46);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        frame();
        push("wall_out_x_t261", 48); push("bounce_no_miss", 0); push("bounce_state", 1);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (miss_seen !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, miss_seen, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
    endtask

    task automatic test_miss();
        do_reset();
        bar_y_t = 10'd0; start = 1'b1; miss_seen = 0;
        for (int t = 0; t <= 156; t++) frame();
        push("pre_miss_state", 1);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end

        frame();
        push("miss_x", 634); push("miss_y", 390); push("miss_pulse", 1); push("miss_state", 2);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(miss) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, miss, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end

        px = 10'd634; py = 10'd390; #1;
        push("miss_ball_hidden", 0);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_on) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_on, e.val); end
        @(negedge clk);
        px = 10'd0; py = 10'd0;
        push("miss_pulse_end", 0);
        e = sb.pop_front(); n_vec++;
        if (int'(miss) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, miss, e.val); end

        start = 1'b0;
        for (int t = 1; t <= 59; t++) frame();
        push("miss_hold_59", 2);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        frame();
        push("miss_done_state", 0); push("miss_done_x", 320); push("miss_done_y", 240); push("miss_pulse_count", 1);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end
        e = sb.pop_front(); n_vec++;
        if (miss_seen !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, miss_seen, e.val); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        bar_y_t = 10'd0; start = 1'b1;
        for (int t = 0; t <= 30; t++) frame();
        push("play_x_t30", 380);
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        push("midrst_state", 0); push("midrst_x", 320); push("midrst_y", 240);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end

        // held tick pixel: exactly one tick means launch only, no motion
        px = 10'd0; py = 10'd481;
        repeat (4) @(negedge clk);
        py = 10'd0;
        push("hold_state", 1); push("hold_x", 320);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        start = 1'b0;
    endtask

    task automatic test_idle();
        do_reset();
        start = 1'b0;
        for (int t = 0; t < 10; t++) frame();
        push("idle_state", 0); push("idle_x", 320); push("idle_y", 240);
        e = sb.pop_front(); n_vec++;
        if (int'(state) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, state, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_x) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_x, e.val); end
        e = sb.pop_front(); n_vec++;
        if (int'(ball_y) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, ball_y, e.val); end
    endtask

    initial begin
        test_reset();
        test_bar_bounce();
        test_miss();
        test_reset_mid_play();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
Per-frame ball motion and pixel-hit generator for the VGA graphics stage. Consumes pixel_x/pixel_y/video_on from the sync generator and the bar's top edge. Produces ball_on/ball_rgb for the downstream colour mux, with the wall and bar remaining higher priority. Owns the ball's position, velocity and play state (IDLE/PLAY/MISS), updated once per frame.

Parameters:
H_DISP, 640, visible pixels per line
V_DISP, 480, visible lines per frame
BALL_SIZE, 8, square ball edge in pixels
BALL_V, 2, speed magnitude, pixels/frame per axis
WALL_X_R, 45, right edge of left wall
BAR_X_L, 450, bar left edge
BAR_X_R, 500, bar right edge
BAR_Y_SIZE, 50, bar height
START_X, 320, ball left edge in IDLE
START_Y, 240, ball top edge in IDLE
MISS_FRAMES, 60, frames held in MISS
BALL_RGB, 3'b010, ball colour

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
video_on  in  1  visible-area flag
bar_y_t  in  10  bar top row; bar spans bar_y_t..bar_y_t+BAR_Y_SIZE-1
start  in  1  level; launches ball from IDLE
ball_on  out  1  current pixel lies inside ball (combinational)
ball_rgb  out  3  constant BALL_RGB
ball_x  out  10  registered ball left edge
ball_y  out  10  registered ball top edge
miss  out  1  one-cycle pulse on miss detection
state_o  out  2  00 IDLE, 01 PLAY, 10 MISS

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, ball_x=START_X, ball_y=START_Y, dx=+BALL_V, dy=+BALL_V, miss=0, miss counter=0. A reset asserted mid-PLAY or mid-MISS overrides everything.
- Frame tick: tick=1 for exactly one clk when (pixel_y==V_DISP+1 && pixel_x==0) is true and was false on the previous clk. Tick is independent of pixel-enable rate. All position, velocity and state updates happen only on tick.
- Internal arithmetic: 11-bit signed, so no wrap. dx and dy are each ±BALL_V.
- IDLE: position held at START. On tick with start=1, go to PLAY. No position change on that tick.
- PLAY, on tick, compute in this order:
  - y_n = clamp(ball_y+dy, 0, V_DISP-BALL_SIZE). If y_n==0, dy:=+V. If y_n==V_DISP-BALL_SIZE, dy:=-V.
  - x_n = ball_x+dx.
  - Wall: if x_n <= WALL_X_R+1, then x_n:=WALL_X_R+1 and dx:=+V.
  - Bar: if dx>0 && x_n+BALL_SIZE-1 >= BAR_X_L && ball_x <= BAR_X_R && y_n+BALL_SIZE-1 >= bar_y_t && y_n <= bar_y_t+BAR_Y_SIZE-1, then x_n:=BAR_X_L-BALL_SIZE and dx:=-V.
  - Miss: otherwise, if x_n+BALL_SIZE-1 >= H_DISP, then state:=MISS, miss=1 for that clk, counter:=0.
  - Bar hit has priority over miss.
- MISS: ball not drawn. Counter increments each tick. On the tick where the counter reaches MISS_FRAMES-1, go to IDLE, restore START position, dx=dy=+V.
- ball_on = video_on && state!=MISS && ball_x<=pixel_x<=ball_x+BALL_SIZE-1 && ball_y<=pixel_y<=ball_y+BALL_SIZE-1. Zero latency from pixel inputs.
- Outputs ball_x/ball_y change only on tick or reset.

Decomposition:
- Shared package vga_pkg: H_DISP, V_DISP, wall and bar geometry constants, state encoding (IDLE/PLAY/MISS).
- One sub-module: frame_tick_gen (pixel_x/pixel_y edge detector → tick), reusable by a future bar controller.

Test Plan:
- Reset → state_o=00, ball_x=320, ball_y=240, miss=0, ball_on=1 at pixel (320,240), 0 at (328,240) and when video_on=0.
- start=1, bar_y_t=340, drive frames → tick 62: ball_x=442, dx=-2 (no miss); tick 63: ball_x=440.
- Continue the same run → tick 116: ball_y=472, dy=-2; tick 117: ball_y=470. Tick 260: ball_x=46, dx=+2.
- bar_y_t=0, start=1 → tick 157: ball_x=634, miss pulses one clk, state_o=10, ball_on=0. 60 ticks later: state_o=00, ball at (320,240).
- rst=1 during PLAY at tick 30 → next clk: state_o=00, ball_x=320, ball_y=240. A pixel pair held at (0,481) for 4 clks gives only one tick.
- start=0 through 10 frames → position unchanged, state stays IDLE.
